// File: rtl/alu_wb_stage.sv
`default_nettype none
// ============================================================================
// alu_wb_stage : execute/writeback stage driving the register file write port,
//                with single-entry bypass and a 16-cycle shift-add multiplier.
// Revision     : 1.0
// ============================================================================
module alu_wb_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [DATA_W-1:0] a_rf,
  input  logic [DATA_W-1:0] b_rf,
  output logic [DATA_W-1:0] wb_din,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic              wb_we,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v,
  output logic              busy
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_SLT = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] wb_din_q, wb_din_d;
  logic [ADDR_W-1:0] wb_waddr_q, wb_waddr_d;
  logic              wb_we_q, wb_we_d;
  logic              z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, acc_q, acc_d;
  logic [ADDR_W-1:0] mul_rd_q, mul_rd_d;
  logic [3:0]        cnt_q, cnt_d;

  logic [DATA_W-1:0] opa, opb, alu_res, mul_sum;
  logic [DATA_W:0]   add_full, sub_full;
  logic              alu_c, alu_v;

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign wb_din   = wb_din_q;
  assign wb_waddr = wb_waddr_q;
  assign wb_we    = wb_we_q;
  assign flag_z   = z_q;
  assign flag_n   = n_q;
  assign flag_c   = c_q;
  assign flag_v   = v_q;

  // Only the value currently on the write port can be forwarded; r0 never is.
  always_comb begin
    opa = (wb_we_q && (wb_waddr_q == ra) && (ra != '0)) ? wb_din_q : a_rf;
    opb = (wb_we_q && (wb_waddr_q == rb) && (rb != '0)) ? wb_din_q : b_rf;
  end

  always_comb begin
    add_full = {1'b0, opa} + {1'b0, opb};
    sub_full = {1'b0, opa} - {1'b0, opb};
    alu_res  = '0;
    alu_c    = c_q;
    alu_v    = v_q;
    case (op)
      OP_ADD: begin
        alu_res = add_full[DATA_W-1:0];
        alu_c   = add_full[DATA_W];
        alu_v   = (opa[DATA_W-1] == opb[DATA_W-1]) && (alu_res[DATA_W-1] != opa[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[DATA_W-1:0];
        alu_c   = sub_full[DATA_W];
        alu_v   = (opa[DATA_W-1] != opb[DATA_W-1]) && (alu_res[DATA_W-1] != opa[DATA_W-1]);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SHL:  alu_res = opa << opb[3:0];
      OP_SHR:  alu_res = opa >> opb[3:0];
      OP_SRA:  alu_res = $signed(opa) >>> opb[3:0];
      OP_MOV:  alu_res = opb;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
      default: alu_res = '0;
    endcase
  end

  assign mul_sum = acc_q + (mul_b_q[cnt_q] ? (mul_a_q << cnt_q) : '0);

  always_comb begin
    state_d    = state_q;
    wb_din_d   = wb_din_q;
    wb_waddr_d = wb_waddr_q;
    wb_we_d    = 1'b0;
    z_d        = z_q;
    n_d        = n_q;
    c_d        = c_q;
    v_d        = v_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_rd_d   = mul_rd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            mul_a_d  = opa;
            mul_b_d  = opb;
            mul_rd_d = rd;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else begin
            wb_din_d   = alu_res;
            wb_waddr_d = rd;
            wb_we_d    = (rd != '0) && (op <= OP_SLT);
            if (op <= OP_SLT) begin
              z_d = (alu_res == '0);
              n_d = alu_res[DATA_W-1];
              c_d = alu_c;
              v_d = alu_v;
            end
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_sum;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          wb_din_d   = mul_sum;
          wb_waddr_d = mul_rd_q;
          wb_we_d    = (mul_rd_q != '0);
          z_d        = (mul_sum == '0);
          n_d        = mul_sum[DATA_W-1];
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wb_din_q   <= '0;
      wb_waddr_q <= '0;
      wb_we_q    <= 1'b0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_rd_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wb_din_q   <= wb_din_d;
      wb_waddr_q <= wb_waddr_d;
      wb_we_q    <= wb_we_d;
      z_q        <= z_d;
      n_q        <= n_d;
      c_q        <= c_d;
      v_q        <= v_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_rd_q   <= mul_rd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
`default_nettype none
// ============================================================================
// tb_alu_wb_stage : directed and randomized checks of alu_wb_stage against a
//                   behavioural reference model.
// Revision        : 1.0
// ============================================================================
module tb_alu_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op, rd, ra, rb;
  logic [15:0] a_rf, b_rf;
  logic [15:0] wb_din;
  logic [3:0]  wb_waddr;
  logic        wb_we, flag_z, flag_n, flag_c, flag_v, busy;

  alu_wb_stage #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .ra(ra), .rb(rb), .a_rf(a_rf), .b_rf(b_rf),
    .wb_din(wb_din), .wb_waddr(wb_waddr), .wb_we(wb_we),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural view of the write port, flags and MUL timer.
  logic [15:0] m_din;
  logic [3:0]  m_waddr;
  logic        m_we, m_z, m_n, m_c, m_v, m_din_known;
  int          m_left;
  logic [15:0] m_prod;
  logic [3:0]  m_prd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_din = 16'h0; m_waddr = 4'h0; m_we = 1'b0;
    m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
    m_din_known = 1'b1; m_left = 0; m_prod = 16'h0; m_prd = 4'h0;
  endtask

  // Predict the architectural state after the coming rising edge.
  task automatic model_edge();
    logic [15:0] a, b, r;
    int ua, ub, sa, sb, sh, full;
    longint p;
    if (m_left > 0) begin
      m_we = 1'b0;
      m_left--;
      if (m_left == 0) begin
        m_din = m_prod; m_waddr = m_prd; m_din_known = 1'b1;
        m_we = (m_prd != 4'd0);
        m_z = (m_prod == 16'h0); m_n = m_prod[15];
      end
    end else if (in_valid) begin
      a = (m_we && m_waddr == ra && ra != 4'd0) ? m_din : a_rf;
      b = (m_we && m_waddr == rb && rb != 4'd0) ? m_din : b_rf;
      ua = int'(a); ub = int'(b);
      sa = $signed(a); sb = $signed(b);
      sh = ub % 16;
      if (op == 4'd8) begin
        p = longint'(ua) * longint'(ub);
        m_prod = 16'(p);
        m_prd = rd; m_left = 16; m_we = 1'b0;
      end else begin
        r = 16'h0;
        case (op)
          4'd0: begin
            full = ua + ub; r = 16'(full);
            m_c = (full > 65535);
            m_v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
          end
          4'd1: begin
            r = 16'(ua - ub);
            m_c = (ua < ub);
            m_v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
          end
          4'd2: r = a & b;
          4'd3: r = a | b;
          4'd4: r = a ^ b;
          4'd5: r = 16'(ua << sh);
          4'd6: r = 16'(ua >> sh);
          4'd7: r = 16'(sa >>> sh);
          4'd9: r = b;
          4'd10: r = (sa < sb) ? 16'd1 : 16'd0;
          default: r = 16'h0;
        endcase
        m_waddr = rd;
        if (op <= 4'd10) begin
          m_din = r; m_din_known = 1'b1;
          m_z = (r == 16'h0); m_n = r[15];
          m_we = (rd != 4'd0);
        end else begin
          m_din_known = 1'b0;
          m_we = 1'b0;
        end
      end
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic compare();
    chk("in_ready", in_ready, m_left == 0);
    chk("busy", busy, m_left != 0);
    chk("wb_we", wb_we, m_we);
    chk("wb_waddr", wb_waddr, m_waddr);
    if (m_din_known) chk("wb_din", wb_din, m_din);
    chk("flags_zncv", {flag_z, flag_n, flag_c, flag_v}, {m_z, m_n, m_c, m_v});
  endtask

  task automatic step(input logic v, input logic [3:0] o, input logic [3:0] d,
                      input logic [3:0] x, input logic [3:0] y,
                      input logic [15:0] a, input logic [15:0] b);
    in_valid = v; op = o; rd = d; ra = x; rb = y; a_rf = a; b_rf = b;
    model_edge();
    @(posedge clk);
    #1;
    compare();
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_val();
    logic [15:0] edge_vals [4];
    edge_vals[0] = 16'h0000; edge_vals[1] = 16'hFFFF;
    edge_vals[2] = 16'h8000; edge_vals[3] = 16'h7FFF;
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 4'd0; rd = 4'd0; ra = 4'd0; rb = 4'd0;
    a_rf = 16'h3333; b_rf = 16'h5555;
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    reset = 1'b0;
    #1;
    compare();
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_wb_din", wb_din, 16'h0000);
    @(negedge clk);

    // ADD r1 = r3 + r5
    step(1'b1, 4'd0, 4'd1, 4'd3, 4'd5, 16'h3333, 16'h5555);
    chk("add_din", wb_din, 16'h8888);
    chk("model_add_din", m_din, 16'h8888);
    chk("add_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0101);
    chk("add_we", {wb_we, wb_waddr}, 5'b1_0001);

    // SUB r2 = r1 - r3, with stale r1 from the file
    step(1'b1, 4'd1, 4'd2, 4'd1, 4'd3, 16'h1111, 16'h3333);
    chk("bypass_sub_din", wb_din, 16'h5555);
    chk("model_bypass_din", m_din, 16'h5555);
    chk("bypass_sub_cv", {flag_c, flag_v}, 2'b01);

    // MUL r4 = 0x2222 * 0x3333; the ADD offered meanwhile must be ignored
    step(1'b1, 4'd8, 4'd4, 4'd6, 4'd7, 16'h2222, 16'h3333);
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 4'd0, 4'd9, 4'd6, 4'd7, 16'h0001, 16'h0001);
      chk("mul_in_ready_low", in_ready, 1'b0);
    end
    step(1'b1, 4'd0, 4'd9, 4'd6, 4'd7, 16'h0001, 16'h0001);
    chk("mul_din", wb_din, 16'h92C6);
    chk("model_mul_din", m_din, 16'h92C6);
    chk("mul_we_n", {wb_we, flag_n, wb_waddr}, 6'b11_0100);

    // Shifts
    step(1'b1, 4'd7, 4'd8, 4'd6, 4'd7, 16'h8888, 16'h4444);
    chk("sra", wb_din, 16'hF888);
    step(1'b1, 4'd6, 4'd8, 4'd6, 4'd7, 16'h8888, 16'h4444);
    chk("shr", wb_din, 16'h0888);
    step(1'b1, 4'd5, 4'd8, 4'd6, 4'd7, 16'h8888, 16'h4444);
    chk("shl", wb_din, 16'h8880);
    chk("model_shl", m_din, 16'h8880);

    // SUB into r0, then NOP
    step(1'b1, 4'd1, 4'd0, 4'd6, 4'd7, 16'h1234, 16'h1234);
    chk("sub_r0_we", wb_we, 1'b0);
    chk("sub_r0_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b1000);
    step(1'b1, 4'd12, 4'd3, 4'd6, 4'd7, 16'h0F0F, 16'h0001);
    chk("nop_we", wb_we, 1'b0);
    chk("nop_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b1000);

    // Reset five cycles into a MUL
    step(1'b1, 4'd8, 4'd5, 4'd6, 4'd7, 16'h0003, 16'h0005);
    repeat (5) step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
    reset = 1'b1;
    model_reset();
    #1;
    compare();
    @(posedge clk); #1;
    compare();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mul_in_ready", in_ready, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
      chk("rst_mul_no_we", wb_we, 1'b0);
    end
    step(1'b1, 4'd0, 4'd1, 4'd3, 4'd5, 16'h0002, 16'h0003);
    chk("post_rst_add", {wb_we, wb_din}, {1'b1, 16'h0005});

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), rand_val(), rand_val());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
